// File: rtl/alu_ops_pkg.sv
// Shared ALU op-code encodings, used by the alu and by anything that
// builds ALU commands.
package alu_ops_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRL = 3'd7;

endpackage

// File: rtl/alu_pkg.sv
// Types shared by the ALU issue block: command and response records and
// the issue sequencer state.
package alu_pkg;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  op;
    } alu_cmd_t;

    typedef struct packed {
        logic [31:0] z;
        logic        equal;
        logic        overflow;
        logic        zero;
    } alu_rsp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Overflow is signed overflow for ADD/SUB and
// 0 for every other op; equal compares the operands, zero tests the result.
module alu
    import alu_ops_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [2:0]  op,
    output logic [31:0] z,
    output logic        equal,
    output logic        overflow,
    output logic        zero
);

    // Result and overflow selection by op code.
    always_comb begin
        z        = '0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                z        = x + y;
                overflow = (x[31] == y[31]) && (z[31] != x[31]);
            end
            ALU_SUB: begin
                z        = x - y;
                overflow = (x[31] != y[31]) && (z[31] != x[31]);
            end
            ALU_AND: z = x & y;
            ALU_OR:  z = x | y;
            ALU_XOR: z = x ^ y;
            ALU_SLT: z = {31'd0, ($signed(x) < $signed(y))};
            ALU_SLL: z = x << y[4:0];
            ALU_SRL: z = x >> y[4:0];
            default: z = '0;
        endcase
    end

    assign equal = (x == y);
    assign zero  = (z == '0);

endmodule

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issue block. DEPTH must be a power of two so
// the pointers wrap naturally; count runs 0..DEPTH. Push when full and pop
// when empty are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  alu_cmd_t                   push_data,
    input  logic                       pop,
    output alu_cmd_t                   head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    alu_cmd_t      mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue block: queues commands in a FIFO, runs them one at a time
// through the alu and holds each result until the consumer takes it.
// Optional feature macro ALU_ISSUE_STICKY_OVF_EN adds a sticky overflow
// flag (sticky_ovf) with its clear input (clr_ovf).
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [2:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_z,
    output logic        rsp_equal,
    output logic        rsp_overflow,
    output logic        rsp_zero,
`ifdef ALU_ISSUE_STICKY_OVF_EN
    input  logic        clr_ovf,
    output logic        sticky_ovf,
`endif
    output logic        busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    alu_state_t    state;
    alu_state_t    state_nxt;
    alu_cmd_t      push_cmd;
    alu_cmd_t      fifo_head;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   alu_x;
    logic [31:0]   alu_y;
    logic [2:0]    alu_op;
    alu_rsp_t      alu_out;
    alu_rsp_t      rsp_q;

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign req_ready = (fifo_count < DEPTH_CNT);
    assign fifo_push = req_valid && req_ready && !fifo_full;
    assign push_cmd  = '{x: req_x, y: req_y, op: req_op};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    alu u_alu (
        .x        (alu_x),
        .y        (alu_y),
        .op       (alu_op),
        .z        (alu_out.z),
        .equal    (alu_out.equal),
        .overflow (alu_out.overflow),
        .zero     (alu_out.zero)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, FIFO pop and ALU operand steering; operands are zero
    // outside EXEC so the alu never sees stale commands.
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        alu_x     = '0;
        alu_y     = '0;
        alu_op    = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = EXEC;
            end
            EXEC: begin
                fifo_pop  = 1'b1;
                alu_x     = fifo_head.x;
                alu_y     = fifo_head.y;
                alu_op    = fifo_head.op;
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = fifo_empty ? IDLE : EXEC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the ALU result at the end of EXEC and hold it through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            rsp_q <= '0;
        else if (state == EXEC) rsp_q <= alu_out;
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    // Sticky overflow: a capture with overflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              sticky_ovf <= 1'b0;
        else if (state == EXEC && alu_out.overflow) sticky_ovf <= 1'b1;
        else if (clr_ovf)                        sticky_ovf <= 1'b0;
    end
`endif

    assign rsp_valid    = (state == RESP);
    assign rsp_z        = rsp_q.z;
    assign rsp_equal    = rsp_q.equal;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_zero     = rsp_q.zero;
    assign busy         = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a queue-based reference model of in-order results,
// checked every cycle, plus directed cases with hand-computed values.
module tb_alu_issue;
    import alu_ops_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic [2:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_z;
    logic        rsp_equal;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        busy;
`ifdef ALU_ISSUE_STICKY_OVF_EN
    logic        clr_ovf = 1'b0;
    logic        sticky_ovf;
`endif

    always #5 clk = ~clk;

    alu_issue #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_z        (rsp_z),
        .rsp_equal    (rsp_equal),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
`ifdef ALU_ISSUE_STICKY_OVF_EN
        .clr_ovf      (clr_ovf),
        .sticky_ovf   (sticky_ovf),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] z;
        logic        eq;
        logic        ovf;
        logic        zr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference ALU from plain wide signed arithmetic.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
        exp_t            e;
        longint          sx;
        longint          sy;
        longint          r;
        logic signed [31:0] t;
        sx    = longint'($signed(x));
        sy    = longint'($signed(y));
        e.ovf = 1'b0;
        case (op)
            ALU_ADD: begin r = sx + sy; t = r[31:0]; e.z = t; e.ovf = (longint'(t) != r); end
            ALU_SUB: begin r = sx - sy; t = r[31:0]; e.z = t; e.ovf = (longint'(t) != r); end
            ALU_AND: e.z = x & y;
            ALU_OR:  e.z = x | y;
            ALU_XOR: e.z = x ^ y;
            ALU_SLT: e.z = (sx < sy) ? 32'd1 : 32'd0;
            ALU_SLL: e.z = x << (y % 32);
            default: e.z = x >> (y % 32);
        endcase
        e.eq = (x == y);
        e.zr = (e.z == 32'd0);
        return e;
    endfunction

    // Compare process: outputs are checked mid-cycle, then this cycle's
    // handshakes are applied to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_rsp_z", rsp_z, 0);
        end else begin
            chk("busy", busy, (exp_q.size() != 0));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got z=%h expected no response (t=%0t)", rsp_z, $time);
                end else begin
                    chk("rsp_z", rsp_z, exp_q[0].z);
                    chk("rsp_equal", rsp_equal, exp_q[0].eq);
                    chk("rsp_overflow", rsp_overflow, exp_q[0].ovf);
                    chk("rsp_zero", rsp_zero, exp_q[0].zr);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) exp_q.push_back(model(req_x, req_y, req_op));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, then wait (bounded) for its response to be held.
    task automatic issue_wait(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op, input string name);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_op    = op;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid) break;
            step();
        end
        chk({name, "_rsp_seen"}, rsp_valid, 1);
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int got;
        int last;
        // Reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ready", req_ready, 1);
        chk("reset_z", rsp_z, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // ADD overflow with exact 2-cycle latency
        req_valid = 1'b1; req_x = 32'h7FFF_FFFF; req_y = 32'h0000_0001; req_op = ALU_ADD;
        step();
        req_valid = 1'b0;
        chk("add_lat_e0", rsp_valid, 0);
        step();
        chk("add_lat_e1", rsp_valid, 0);
        step();
        chk("add_lat_e2", rsp_valid, 1);
        chk("add_z", rsp_z, 32'h8000_0000);
        chk("add_ovf", rsp_overflow, 1);
        chk("add_zero", rsp_zero, 0);
        chk("add_eq", rsp_equal, 0);
        release_rsp();
        chk("add_done", rsp_valid, 0);

        // SUB of equal operands, AND of disjoint patterns
        issue_wait(32'h0C00_00FF, 32'h0C00_00FF, ALU_SUB, "sub");
        chk("sub_z", rsp_z, 0);
        chk("sub_zero", rsp_zero, 1);
        chk("sub_eq", rsp_equal, 1);
        chk("sub_ovf", rsp_overflow, 0);
        release_rsp();
        issue_wait(32'h5555_5555, 32'hAAAA_AAAA, ALU_AND, "and");
        chk("and_z", rsp_z, 0);
        chk("and_zero", rsp_zero, 1);
        chk("and_eq", rsp_equal, 0);
        release_rsp();

        // Backpressure: six offered, five accepted
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_x = 32'(i * 17 + 3); req_y = 32'(i + 100); req_op = ALU_ADD;
            if (req_ready) acc++;
            step();
        end
        req_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_ready_low", req_ready, 0);
        rsp_ready = 1'b1;
        got = 0;
        last = -1;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid) begin
                if (got == 0) chk("bp_first_z", rsp_z, 32'd103);
                if (last >= 0) chk("bp_gap", c - last, 2);
                got++;
                last = c;
            end
            step();
        end
        rsp_ready = 1'b0;
        chk("bp_count", got, 5);
        chk("bp_idle_busy", busy, 0);

        // Reset while RESP with three queued
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_x = 32'(i); req_y = 32'd1; req_op = ALU_SUB;
            step();
        end
        req_valid = 1'b0;
        chk("mid_in_resp", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_z", rsp_z, 0);
        step(); step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) got++;
            step();
        end
        rsp_ready = 1'b0;
        chk("mid_no_rsp", got, 0);

`ifdef ALU_ISSUE_STICKY_OVF_EN
        // Sticky overflow
        issue_wait(32'h8000_0000, 32'h8000_0000, ALU_ADD, "sticky_add");
        chk("sticky_set", sticky_ovf, 1);
        release_rsp();
        issue_wait(32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, "sticky_and");
        chk("sticky_hold", sticky_ovf, 1);
        release_rsp();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("sticky_clr", sticky_ovf, 0);
`endif

        // Randomized traffic with random backpressure
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_x     = pick();
            req_y     = ($urandom_range(0, 7) == 0) ? req_x : pick();
            req_op    = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (!busy) break;
            step();
        end
        chk("drain_busy", busy, 0);
        chk("drain_model_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  command offered.
REQ-005 SHALL have port req_ready  output  1  command FIFO can accept.
REQ-006 SHALL have ports req_x, req_y  input  32 each  ALU operands.
REQ-007 SHALL have port req_op  input  3  ALU op code (shared ALU op encodings).
REQ-008 SHALL have port rsp_valid  output  1  result held.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-010 SHALL have port rsp_z  output  32  registered ALU result.
REQ-011 SHALL have ports rsp_equal, rsp_overflow, rsp_zero  output  1 each  registered ALU flags.
REQ-012 SHALL have port busy  output  1  high when FIFO non-empty or state != IDLE.

Function
REQ-013 SHALL accept a command on any rising edge with req_valid && req_ready; req_ready = (count < DEPTH), independent of same-cycle pop.
REQ-014 SHALL keep FIFO read/write pointers modulo DEPTH and a count of width $clog2(DEPTH+1); results leave in acceptance order.
REQ-015 SHALL implement states IDLE, EXEC, RESP.
REQ-016 IDLE -> EXEC when FIFO non-empty; else stay IDLE.
REQ-017 EXEC: pop FIFO head, drive it to the alu instance, capture z/equal/overflow/zero into rsp registers at end of cycle; EXEC -> RESP unconditionally.
REQ-018 RESP: rsp_valid=1, rsp_* stable; on rsp_ready: -> EXEC if FIFO non-empty, else -> IDLE; without rsp_ready stay RESP.
REQ-019 Latency SHALL be 2 cycles: command accepted at edge N into empty idle block gives rsp_valid=1 after edge N+2.
REQ-020 Push at edge where FIFO is empty and state IDLE SHALL not bypass the FIFO (IDLE sees it next cycle).
REQ-021 Simultaneous push and pop SHALL leave count unchanged; push when full SHALL be impossible (ready low).
REQ-022 ALU inputs SHALL be zero in IDLE/RESP so the alu sees no spurious operands.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, pointers/count 0, rsp_valid 0, rsp_z 0, all rsp flags 0, busy 0; req_ready 1 once count is 0.
REQ-024 Reset mid-operation SHALL discard all queued commands and any held result; no response for them ever appears.

Configuration
REQ-025 With ALU_ISSUE_STICKY_OVF_EN defined, SHALL add ports clr_ovf input 1 and sticky_ovf output 1; sticky_ovf sets at EXEC capture when ALU overflow=1, clears on clr_ovf (set wins if same cycle), resets to 0.
REQ-026 Without ALU_ISSUE_STICKY_OVF_EN, those ports and the register SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package alu_pkg SHALL hold alu_cmd_t {x, y, op}, alu_rsp_t {z, equal, overflow, zero} and the state enum; op codes stay in the shared ALU header.
REQ-028 Command storage SHALL be sub-module alu_cmd_fifo (parameter DEPTH, push/pop/full/empty/count); the existing alu is instantiated unchanged.

Verification
REQ-029 Reset -> rsp_valid=0, busy=0, req_ready=1, rsp_z=0.
REQ-030 ADD x=0x7FFFFFFF y=0x00000001, accepted edge 0 -> rsp_valid after edge 2, z=0x80000000, overflow=1, zero=0, equal=0.
REQ-031 SUB x=y=0x0C0000FF -> z=0, zero=1, equal=1, overflow=0; AND 0x55555555,0xAAAAAAAA -> z=0, zero=1, equal=0.
REQ-032 rsp_ready=0, offer 6 commands (DEPTH=4) -> 5 accepted, req_ready=0; release rsp_ready -> 5 results in order, one per 2 cycles, then IDLE, busy=0.
REQ-033 rst_n pulsed low while RESP with 3 queued -> rsp_valid=0 immediately, no further responses, req_ready=1.
REQ-034 ALU_ISSUE_STICKY_OVF_EN: ADD 0x80000000+0x80000000 -> sticky_ovf=1, stays 1 across following AND, clears cycle after clr_ovf pulse.
